instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- RV32I fetch stage, directly upstream of the instruction parser.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned words with their PCs in a small FIFO queue, then presents one {instruction, pc} per handshake to decode.
- On a redirect from execute (branch/jal), flushes the queue and discards responses that are still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- DEPTH, 2, queue entries; power of two, at least 2. It also bounds entries plus in-flight requests.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  32  fetch address; always equals the PC.
- imem_rsp_valid  input  1  response word valid; in order; cannot be backpressured.
- imem_rsp_data  input  32  returned instruction word.
- instr_valid  output  1  queue head is valid for decode.
- instr_ready  input  1  decode consumes the head.
- instruction  output  32  head instruction word; feeds the parser's instruction input.
- instr_pc  output  32  PC of the head word.
- redirect_valid  input  1  PC redirect request.
- redirect_pc  input  32  redirect target.
- fetch_fault  output  1  misaligned redirect flag; exists only with the optional feature.

Behaviour:
- Reset (async assert) clears state:
  - pc=RESET_PC, wr_ptr=rd_ptr=count=0, outstanding=0, discard=0, state=IDLE.
  - All outputs are 0 except imem_addr, which equals RESET_PC.
- FSM states:
  - IDLE: one cycle after reset deassertion, then RUN.
  - RUN: normal fetch.
  - DRAIN: discarding stale responses.
- Credit: credit = DEPTH - count - outstanding, computed before this cycle's updates. Never negative.
- imem_req_valid = (state==RUN) && credit>0 && !redirect_valid.
- Request handshake (req_valid && req_ready): pc <= pc+4 (wraps modulo 2^32) and outstanding increments.
- Response handling:
  - In RUN, a response is written to queue[wr_ptr] together with the PC of the oldest in-flight request; outstanding decrements.
  - The in-flight PC comes from a DEPTH-deep PC tag FIFO, pushed on each request handshake.
  - The queue cannot overflow, by the credit rule.
- Output:
  - instr_valid = (count!=0) && !redirect_valid.
  - instruction and instr_pc come from queue[rd_ptr].
  - On a valid/ready handshake, rd_ptr and count advance.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Response to instr_valid: 1 cycle; no bypass.
  - Reset deassert to first request: 1 cycle (the IDLE cycle).
- Simultaneous events:
  - Response and dequeue in the same cycle: count is unchanged.
  - Request and response in the same cycle: outstanding is unchanged.
- Redirect (any state, highest priority):
  - Queue is cleared (count=0, pointers reset) and the PC tag FIFO is cleared.
  - pc <= redirect_pc.
  - discard <= outstanding minus 1 if a response arrives this cycle; that response is dropped.
  - outstanding is reduced accordingly.
  - State goes to DRAIN if discard > 0, otherwise RUN.
  - No dequeue happens in the redirect cycle.
- DRAIN:
  - No requests are issued.
  - Each response is dropped and decrements both discard and outstanding.
  - When discard reaches 0, go to RUN on the next cycle.
  - A new redirect during DRAIN restarts the discard count from the current outstanding.
- Empty queue: instr_valid=0; instruction and instr_pc hold their last values (don't-care).
- Full queue: credit=0, so req_valid=0 until a dequeue.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (registered) and loads pc with the target.
  - The unit enters a HALT state: no requests, no instr_valid.
  - fetch_fault and HALT are cleared only by reset or by a subsequent aligned redirect.
- Undefined:
  - The fetch_fault port is absent; redirect_pc[1:0] is ignored and forced to 0.

Test Plan:
- Reset -> IDLE then RUN. Request 1: imem_addr=RESET_PC, one cycle after rst_n rises. With ready=1 every cycle and rsp_valid the cycle after each handshake, decode sees PCs 0x0, 0x4, 0x8 in order, matching the data words.
- instr_ready=0, ready=1 -> at most 2 requests issued; count=2; req_valid=0. Releasing instr_ready resumes requests and no word is lost or duplicated.
- 2 requests in flight, redirect_pc=0x100 -> both late responses dropped in DRAIN; the next request is 0x100; the first instr_pc seen is 0x100.
- Redirect in the same cycle as a response and as instr_ready=1 -> response dropped, head not consumed, instr_valid=0 that cycle, the next fetch address is redirect_pc.
- pc=0xFFFF_FFFC fetch -> the next address wraps to 0x0000_0000.
- FETCH_MISALIGN_CHECK_EN, redirect_pc=0x102 -> fetch_fault=1, no requests issued. A following redirect to 0x200 clears the fault and fetch resumes at 0x200.
- Reset asserted mid-DRAIN -> all counters clear and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// RV32I fetch stage sitting directly upstream of the instruction parser.
// Holds the program counter, issues in-order word requests to instruction
// memory, buffers returned words together with their PCs in a small queue and
// hands one {instruction, pc} pair per handshake to decode. A redirect from
// execute flushes the queue and drops any responses that are still in flight.
//
// Parameters
//   RESET_PC  PC loaded on reset.
//   DEPTH     Queue entries (power of two, >= 2). Also bounds the sum of
//             queued words and in-flight requests.
//
// Ports
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_addr       out  fetch address (always the current PC)
//   imem_rsp_valid  in   response word valid (in order, never stalled)
//   imem_rsp_data   in   returned instruction word
//   instr_valid     out  queue head valid for decode
//   instr_ready     in   decode consumes the head
//   instruction     out  head instruction word
//   instr_pc        out  PC of the head word
//   redirect_valid  in   PC redirect request (highest priority)
//   redirect_pc     in   redirect target
//   fetch_fault     out  misaligned-redirect flag (only with the macro below)
//
// Build option
//   FETCH_MISALIGN_CHECK_EN  When defined, a redirect to a non word-aligned
//                            target raises fetch_fault and parks the unit in
//                            HALT until reset or an aligned redirect. When
//                            undefined, redirect_pc[1:0] is forced to zero and
//                            the fetch_fault port does not exist.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    S_HALT  = 2'd3
`endif
  } state_e;

  // Control state
  state_e          state_q,   state_d;
  logic [31:0]     pc_q,      pc_d;
  logic [PW-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0]   count_q,   count_d;
  logic [CW-1:0]   outst_q,   outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [PW-1:0]   tag_wr_q,  tag_wr_d;
  logic [PW-1:0]   tag_rd_q,  tag_rd_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            fault_q,   fault_d;
`endif

  // Storage: instruction queue, PC of each queued word, PC tags of requests
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     ipc_mem_q   [DEPTH];
  logic [31:0]     tag_mem_q   [DEPTH];

  logic            q_we;
  logic            tag_we;
  logic [CW-1:0]   credit;
  logic            req_fire;
  logic            deq;
  logic [CW-1:0]   rsp_dec;
  logic [CW-1:0]   disc_dec;
  logic [31:0]     rdr_target;
  logic            rdr_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign rdr_target     = redirect_pc;
  assign rdr_misaligned = |redirect_pc[1:0];
  assign fetch_fault    = fault_q;
`else
  // Low address bits of a redirect are meaningless without the check; the
  // target is always treated as word aligned.
  logic unused_rdr_lsbs;
  assign unused_rdr_lsbs = ^redirect_pc[1:0];
  assign rdr_target      = {redirect_pc[31:2], 2'b00};
  assign rdr_misaligned  = 1'b0;
`endif

  // Slots not yet claimed by a queued word or an in-flight request. Every
  // outstanding request is guaranteed a queue slot, so a response can always
  // be written without backpressure.
  assign credit         = DEPTH_C - count_q - outst_q;

  assign imem_req_valid = (state_q == S_RUN) && (credit != '0) && !redirect_valid;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_addr      = pc_q;

  assign instr_valid    = (count_q != '0) && !redirect_valid;
  assign deq            = instr_valid && instr_ready;
  assign instruction    = instr_mem_q[rd_ptr_q];
  assign instr_pc       = ipc_mem_q[rd_ptr_q];

  // A response only ever retires a request that is actually in flight.
  assign rsp_dec  = CW'(imem_rsp_valid && (outst_q != '0));
  assign disc_dec = CW'(imem_rsp_valid && (discard_q != '0));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d   = fault_q;
`endif
    q_we      = 1'b0;
    tag_we    = 1'b0;

    if (redirect_valid) begin
      // Flush everything buffered. Requests still in flight become stale and
      // their responses must be swallowed; a response arriving right now is
      // one of them and is dropped immediately.
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      tag_wr_d  = '0;
      tag_rd_d  = '0;
      pc_d      = rdr_target;
      outst_d   = outst_q - rsp_dec;
      discard_d = outst_q - rsp_dec;
      state_d   = (discard_d != '0) ? S_DRAIN : S_RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_d   = rdr_misaligned;
      if (rdr_misaligned) begin
        state_d = S_HALT;
      end
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
        end

        S_RUN: begin
          if (req_fire) begin
            pc_d     = pc_q + 32'd4;
            tag_we   = 1'b1;
            tag_wr_d = tag_wr_q + PW'(1);
          end
          if (imem_rsp_valid) begin
            // Oldest in-flight tag pairs with this in-order response.
            q_we     = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            tag_rd_d = tag_rd_q + PW'(1);
          end
          if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
          outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
          count_d = count_q + CW'(imem_rsp_valid) - CW'(deq);
        end

        S_DRAIN: begin
          outst_d   = outst_q - rsp_dec;
          discard_d = discard_q - disc_dec;
          if (discard_d == '0) begin
            state_d = S_RUN;
          end
        end

`ifdef FETCH_MISALIGN_CHECK_EN
        S_HALT: begin
          // Parked: no fetches, but stale responses still retire.
          outst_d   = outst_q - rsp_dec;
          discard_d = discard_q - disc_dec;
        end
`endif

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q   <= fault_d;
`endif
    end
  end

  // Storage is cleared on reset so that instruction/instr_pc read as zero
  // straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        ipc_mem_q[i]   <= '0;
        tag_mem_q[i]   <= '0;
      end
    end else begin
      if (tag_we) begin
        tag_mem_q[tag_wr_q] <= pc_q;
      end
      if (q_we) begin
        instr_mem_q[wr_ptr_q] <= imem_rsp_data;
        ipc_mem_q[wr_ptr_q]   <= tag_mem_q[tag_rd_q];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory contents: each word is a fixed function of its address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Called at a falling edge; inputs settle, outputs are sampled 1 time unit later.
  task automatic set_in(input logic rdr, input logic [31:0] rpc, input logic rq,
                        input logic rv, input logic [31:0] rd, input logic ir);
    redirect_valid = rdr;
    redirect_pc    = rpc;
    imem_req_ready = rq;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    instr_ready    = ir;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1 ({tag, "_req_valid"},   imem_req_valid, 1'b0);
    chk32({tag, "_addr"},        imem_addr,      RESET_PC);
    chk1 ({tag, "_instr_valid"}, instr_valid,    1'b0);
    chk32({tag, "_instruction"}, instruction,    32'h0);
    chk32({tag, "_instr_pc"},    instr_pc,       32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk1 ({tag, "_fetch_fault"}, fetch_fault,    1'b0);
`endif
  endtask

  // Leaves the bench at the falling edge where rst_n is released (IDLE cycle).
  task automatic do_reset();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Table-driven directed sequence
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        rdr;
    logic [31:0] rpc;
    logic        rq;
    logic        rv;
    logic [31:0] rsp_pc;
    logic        ir;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic rdr, input logic [31:0] rpc, input logic rq,
                              input logic rv, input logic [31:0] rsp_pc, input logic ir,
                              input logic e_rv, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_pc);
    vec_t v;
    v.rdr = rdr; v.rpc = rpc; v.rq = rq; v.rv = rv; v.rsp_pc = rsp_pc; v.ir = ir;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic test_table();
    vec_t tv[$];
    // rdr rpc     rq rv rsp_pc  ir | e_rv e_addr  e_iv e_pc
    tv.push_back(mk(0, 32'h0,   1, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0));   // IDLE
    tv.push_back(mk(0, 32'h0,   1, 0, 32'h0,   1,   1, 32'h0,   0, 32'h0));   // first request
    tv.push_back(mk(0, 32'h0,   1, 1, 32'h0,   1,   1, 32'h4,   0, 32'h0));
    tv.push_back(mk(0, 32'h0,   1, 1, 32'h4,   1,   0, 32'h8,   1, 32'h0));   // credit exhausted
    tv.push_back(mk(0, 32'h0,   1, 0, 32'h0,   1,   1, 32'h8,   1, 32'h4));
    tv.push_back(mk(0, 32'h0,   0, 1, 32'h8,   1,   1, 32'hC,   0, 32'h0));
    tv.push_back(mk(0, 32'h0,   1, 0, 32'h0,   0,   1, 32'hC,   1, 32'h8));   // decode stalls
    tv.push_back(mk(0, 32'h0,   1, 1, 32'hC,   0,   0, 32'h10,  1, 32'h8));
    tv.push_back(mk(0, 32'h0,   1, 0, 32'h0,   0,   0, 32'h10,  1, 32'h8));   // queue full
    tv.push_back(mk(0, 32'h0,   1, 0, 32'h0,   1,   0, 32'h10,  1, 32'h8));   // release
    tv.push_back(mk(0, 32'h0,   1, 0, 32'h0,   1,   1, 32'h10,  1, 32'hC));
    tv.push_back(mk(0, 32'h0,   0, 1, 32'h10,  0,   1, 32'h14,  0, 32'h0));
    tv.push_back(mk(0, 32'h0,   1, 0, 32'h0,   0,   1, 32'h14,  1, 32'h10));
    tv.push_back(mk(1, 32'h100, 1, 1, 32'h14,  1,   0, 32'h18,  0, 32'h0));   // redirect+rsp+ready
    tv.push_back(mk(0, 32'h0,   1, 0, 32'h0,   0,   1, 32'h100, 0, 32'h0));
    tv.push_back(mk(0, 32'h0,   0, 1, 32'h100, 0,   1, 32'h104, 0, 32'h0));
    tv.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0,   1, 32'h104, 1, 32'h100));

    do_reset();
    foreach (tv[i]) begin
      set_in(tv[i].rdr, tv[i].rpc, tv[i].rq, tv[i].rv,
             tv[i].rv ? data_of(tv[i].rsp_pc) : 32'h0, tv[i].ir);
      chk1 ($sformatf("tv%0d_req_valid", i),   imem_req_valid, tv[i].e_rv);
      chk32($sformatf("tv%0d_addr", i),        imem_addr,      tv[i].e_addr);
      chk1 ($sformatf("tv%0d_instr_valid", i), instr_valid,    tv[i].e_iv);
      if (tv[i].e_iv) begin
        chk32($sformatf("tv%0d_instr_pc", i),    instr_pc,    tv[i].e_pc);
        chk32($sformatf("tv%0d_instruction", i), instruction, data_of(tv[i].e_pc));
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Hand-written multi-cycle corner cases
  // ---------------------------------------------------------------------------
  task automatic test_drain();
    do_reset();
    set_in(0, '0, 1, 0, '0, 1);           chk1("dr_idle_req", imem_req_valid, 1'b0); @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1);           chk32("dr_addr0", imem_addr, 32'h0);       @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1);           chk32("dr_addr4", imem_addr, 32'h4);       @(negedge clk);
    set_in(1, 32'h100, 1, 0, '0, 1);      chk1("dr_rdr_req", imem_req_valid, 1'b0);  @(negedge clk);
    set_in(0, '0, 1, 1, data_of(32'h0), 1);
    chk1("dr_drain1_req", imem_req_valid, 1'b0);
    chk1("dr_drain1_iv", instr_valid, 1'b0);
    chk32("dr_drain1_addr", imem_addr, 32'h100);
    @(negedge clk);
    set_in(0, '0, 1, 1, data_of(32'h4), 1);
    chk1("dr_drain2_req", imem_req_valid, 1'b0);
    chk1("dr_drain2_iv", instr_valid, 1'b0);
    @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1);
    chk1("dr_resume_req", imem_req_valid, 1'b1);
    chk32("dr_resume_addr", imem_addr, 32'h100);
    chk1("dr_resume_iv", instr_valid, 1'b0);
    @(negedge clk);
    set_in(0, '0, 0, 1, data_of(32'h100), 1); chk1("dr_nobypass_iv", instr_valid, 1'b0); @(negedge clk);
    set_in(0, '0, 0, 0, '0, 1);
    chk1("dr_head_iv", instr_valid, 1'b1);
    chk32("dr_head_pc", instr_pc, 32'h100);
    chk32("dr_head_instr", instruction, data_of(32'h100));
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    set_in(0, '0, 1, 0, '0, 1); @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1); @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1); @(negedge clk);
    set_in(1, 32'h300, 1, 0, '0, 1); @(negedge clk);
    set_in(0, '0, 1, 1, data_of(32'h0), 1);
    chk1("rmd_drain_req", imem_req_valid, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rmd");
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, '0, 1, 0, '0, 1); chk1("rmd_idle_req", imem_req_valid, 1'b0); @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1);
    chk1("rmd_req1", imem_req_valid, 1'b1);
    chk32("rmd_addr1", imem_addr, RESET_PC);
    @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1);
    chk1("rmd_req2", imem_req_valid, 1'b1);
    chk32("rmd_addr2", imem_addr, RESET_PC + 32'h4);
    @(negedge clk);
    set_in(0, '0, 1, 1, data_of(RESET_PC), 1); chk1("rmd_full_req", imem_req_valid, 1'b0); @(negedge clk);
    set_in(0, '0, 0, 1, data_of(RESET_PC + 32'h4), 1);
    chk1("rmd_iv1", instr_valid, 1'b1);
    chk32("rmd_pc1", instr_pc, RESET_PC);
    @(negedge clk);
    set_in(0, '0, 0, 0, '0, 1);
    chk1("rmd_iv2", instr_valid, 1'b1);
    chk32("rmd_pc2", instr_pc, RESET_PC + 32'h4);
    chk32("rmd_instr2", instruction, data_of(RESET_PC + 32'h4));
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(0, '0, 0, 0, '0, 0); @(negedge clk);
    set_in(1, 32'hFFFF_FFFC, 1, 0, '0, 1); @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1);
    chk1("wr_req", imem_req_valid, 1'b1);
    chk32("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    set_in(0, '0, 0, 1, data_of(32'hFFFF_FFFC), 1);
    chk32("wr_addr_wrapped", imem_addr, 32'h0000_0000);
    @(negedge clk);
    set_in(0, '0, 0, 0, '0, 1);
    chk1("wr_iv", instr_valid, 1'b1);
    chk32("wr_pc", instr_pc, 32'hFFFF_FFFC);
    @(negedge clk);
  endtask

  task automatic test_misalign();
    do_reset();
    set_in(0, '0, 0, 0, '0, 0); @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
    set_in(1, 32'h102, 1, 0, '0, 1); @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      set_in(0, '0, 1, 0, '0, 1);
      chk1($sformatf("ma_fault%0d", k), fetch_fault, 1'b1);
      chk1($sformatf("ma_halt_req%0d", k), imem_req_valid, 1'b0);
      chk1($sformatf("ma_halt_iv%0d", k), instr_valid, 1'b0);
      chk32($sformatf("ma_halt_addr%0d", k), imem_addr, 32'h102);
      @(negedge clk);
    end
    set_in(1, 32'h200, 1, 0, '0, 1); @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1);
    chk1("ma_fault_clear", fetch_fault, 1'b0);
    chk1("ma_resume_req", imem_req_valid, 1'b1);
    chk32("ma_resume_addr", imem_addr, 32'h200);
    @(negedge clk);
    set_in(0, '0, 0, 1, data_of(32'h200), 1); @(negedge clk);
    set_in(0, '0, 0, 0, '0, 1);
    chk1("ma_iv", instr_valid, 1'b1);
    chk32("ma_pc", instr_pc, 32'h200);
    @(negedge clk);
`else
    set_in(1, 32'h103, 1, 0, '0, 1); @(negedge clk);
    set_in(0, '0, 1, 0, '0, 1);
    chk1("al_req", imem_req_valid, 1'b1);
    chk32("al_addr", imem_addr, 32'h100);
    @(negedge clk);
    set_in(0, '0, 0, 1, data_of(32'h100), 1); @(negedge clk);
    set_in(0, '0, 0, 0, '0, 1);
    chk1("al_iv", instr_valid, 1'b1);
    chk32("al_pc", instr_pc, 32'h100);
    @(negedge clk);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run against a transaction-level reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    int          gen;
    int          due;
  } pend_t;

  task automatic test_random(input int ncyc);
    pend_t       pend[$];
    logic [31:0] mq[$];          // PCs requested since the last redirect, not yet consumed
    pend_t       p;
    int          gen = 0, avail = 0, last_due = -1, stale, due;
    logic [31:0] epc = RESET_PC;
    bit          first = 1'b1;
    logic        rdr, rq, ir, rv, live, erv, eiv;
    logic [31:0] rpc, rd;

    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      stale = 0;
      foreach (pend[i]) if (pend[i].gen != gen) stale++;
      rv = 1'b0; live = 1'b0; rd = $urandom;
      if (pend.size() > 0 && pend[0].due <= c) begin
        p    = pend.pop_front();
        rv   = 1'b1;
        rd   = data_of(p.addr);
        live = (p.gen == gen);
      end
      rdr = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2))
                                         : ($urandom & 32'hFFFF_FFFC);
      rq  = ($urandom_range(0, 3) != 0);
      ir  = ($urandom_range(0, 2) != 0);
      set_in(rdr, rpc, rq, rv, rd, ir);

      erv = !rdr && !first && (stale == 0) && (mq.size() < DEPTH);
      eiv = !rdr && (avail > 0);
      chk1 ($sformatf("rnd%0d_req_valid", c),   imem_req_valid, erv);
      chk32($sformatf("rnd%0d_addr", c),        imem_addr,      epc);
      chk1 ($sformatf("rnd%0d_instr_valid", c), instr_valid,    eiv);
      if (eiv) begin
        chk32($sformatf("rnd%0d_instr_pc", c),    instr_pc,    mq[0]);
        chk32($sformatf("rnd%0d_instruction", c), instruction, data_of(mq[0]));
      end

      if (rdr) begin
        gen++;
        mq.delete();
        avail = 0;
        epc   = rpc;
      end else begin
        if (erv && rq) begin
          due = c + 1 + int'($urandom_range(0, 2));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          p.addr = epc; p.gen = gen; p.due = due;
          pend.push_back(p);
          mq.push_back(epc);
          epc = epc + 32'd4;
        end
        if (eiv && ir) begin
          void'(mq.pop_front());
          avail--;
        end
        if (rv && live) avail++;
      end
      first = 1'b0;
      @(negedge clk);
    end
    set_in(0, '0, 0, 0, '0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_table();
    test_drain();
    test_reset_mid_drain();
    test_wrap();
    test_misalign();
    test_random(4000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
